// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

  // Sequencer states: one packet byte is walked through LOAD/SEND/WAIT_HI/WAIT_LO
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO
  } arb_state_t;

  // Sync byte plus ID byte ahead of the payload
  localparam int HDR_LEN = 2;
  // Checksum byte behind the payload
  localparam int TRL_LEN = 1;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundles the source request side and the UART byte handshake of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: tx_busy from the UART stalls the arbiter between bytes.
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_BYTES = 2
);
  logic [NUM_SRC-1:0]              req;
  logic [NUM_SRC*DATA_BYTES*8-1:0] data;
  logic [NUM_SRC-1:0]              ack;
  logic                            tx_ena;
  logic [7:0]                      tx_data;
  logic                            tx_busy;
  logic                            busy;
  logic [2:0]                      cur_src;

  // Arbiter side: consumes requests and UART status, drives grants and bytes
  modport master (
    input  req, data, tx_busy,
    output ack, tx_ena, tx_data, busy, cur_src
  );

  // Environment side: sources plus the UART
  modport slave (
    output req, data, tx_busy,
    input  ack, tx_ena, tx_data, busy, cur_src
  );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin pick: first asserted request strictly after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; valid is low when no source requests.
module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         ptr,
  output logic               valid,
  output logic [2:0]         winner
);

  // Scan from the farthest candidate back to ptr+1 so the nearest requester is written last
  always_comb begin
    int                 idx;
    logic [NUM_SRC-1:0] rot;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    rot    = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      rot = req >> idx;
      if (rot[0]) begin
        valid  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART among NUM_SRC sources: round-robin grant, snapshot, framed byte stream.
// Latency: req in IDLE -> ack in 2nd cycle, first tx_ena in 4th; 2 cycles from tx_busy fall to next tx_ena.
// Backpressure: waits on tx_busy low before granting and between bytes; no timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_SRC    = 4,
  parameter int         DATA_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int         WORD_W   = DATA_BYTES * 8;
  localparam logic [2:0] LAST_IDX = 3'(HDR_LEN + DATA_BYTES + TRL_LEN - 1);

  arb_state_t          state, state_nxt;
  logic [2:0]          ptr;
  logic [WORD_W-1:0]   word;
  logic [2:0]          idx;
  logic [7:0]          tx_byte;
  logic                busy_q;
  logic [2:0]          cur_src_q;
  logic [NUM_SRC-1:0]  ack_vec;
  logic                do_grant;
  logic                arb_valid;
  logic [2:0]          arb_winner;
  logic [7:0]          cur_byte;
  logic [7:0]          chk_byte;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req    (bus.req),
    .ptr    (ptr),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the grant pulse; a request dropped before GRANT falls back to IDLE
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    ack_vec   = '0;
    case (state)
      ST_IDLE:    if (|bus.req && !bus.tx_busy) state_nxt = ST_GRANT;
      ST_GRANT: begin
        if (arb_valid) begin
          do_grant  = 1'b1;
          ack_vec   = {{(NUM_SRC-1){1'b0}}, 1'b1} << arb_winner;
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD:    state_nxt = ST_SEND;
      ST_SEND:    state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (bus.tx_busy) state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (!bus.tx_busy) state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_LOAD;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Byte mux over the frozen snapshot: sync, id, payload MSB-first, xor checksum
  always_comb begin
    logic [WORD_W-1:0] sh;
    int                pi;
    chk_byte = {5'b0, cur_src_q};
    sh       = '0;
    pi       = 0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      sh       = word >> (b * 8);
      chk_byte = chk_byte ^ sh[7:0];
    end
    cur_byte = SYNC_BYTE;
    if (idx == 3'd1) begin
      cur_byte = {5'b0, cur_src_q};
    end else if (idx == LAST_IDX) begin
      cur_byte = chk_byte;
    end else if (idx >= 3'd2) begin
      pi       = DATA_BYTES + 1 - int'(idx);
      sh       = word >> (pi * 8);
      cur_byte = sh[7:0];
    end
  end

  // Snapshot, pointer, byte index and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 3'(NUM_SRC - 1);
      word      <= '0;
      idx       <= '0;
      tx_byte   <= '0;
      busy_q    <= 1'b0;
      cur_src_q <= '0;
    end else begin
      if (do_grant) begin
        ptr       <= arb_winner;
        word      <= WORD_W'(bus.data >> (int'(arb_winner) * WORD_W));
        cur_src_q <= arb_winner;
        idx       <= '0;
        busy_q    <= 1'b1;
      end
      if (state == ST_LOAD) tx_byte <= cur_byte;
      if (state == ST_WAIT_LO && !bus.tx_busy) begin
        if (idx == LAST_IDX) busy_q <= 1'b0;
        else                 idx    <= idx + 3'd1;
      end
    end
  end

  assign bus.ack     = ack_vec;
  assign bus.tx_ena  = (state == ST_SEND);
  assign bus.tx_data = tx_byte;
  assign bus.busy    = busy_q;
  assign bus.cur_src = cur_src_q;

endmodule
